fft_frame_buffer: RTL
=====================

Name: fft_frame_buffer

Overview:
- Parametrised, double-buffered (ping-pong) sample store that feeds the parallel-input FFT stage.
- Accepts a serial sample stream with a valid/ready handshake and writes each sample at its bit-reversed (or natural) index.
- Presents a complete N-sample frame as a flat N*MSB bus with a frame_valid/frame_ack handshake.
- While the FFT consumes one bank, the next frame loads into the other, so loading and calculation overlap.

Parameters:
- N, 16, FFT points per frame; power of two, >= 4.
- MSB, 16, sample width in bits (complex: real in upper MSB/2, imag in lower MSB/2; opaque to this block).
- BITREV, 1, 1 = store sample k at bitrev(k); 0 = natural order.
- USE_LAST, 1, 1 = honour s_last framing; 0 = ignore s_last, frames are always exactly N samples.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input sample valid
- s_data  in  MSB  input sample
- s_last  in  1  marks final sample of a frame
- s_ready  out  1  block can accept a sample this cycle
- frame_valid  out  1  a full bank is available
- frame_data  out  N*MSB  full bank contents; entry i at bits [i*MSB +: MSB]
- frame_ack  in  1  consumer has taken the frame; releases the bank
- fill_level  out  $clog2(N)+1  samples written into the current write bank
- err_len  out  1  sticky: a frame closed with an s_last/length mismatch

Behaviour:
- Reset (rst=1 at a clk edge):
  - Both banks are zeroed; full[1:0]=0; wr_bank=0; rd_bank=0; wr_cnt=0; err_len=0.
  - Outputs while in reset and on the first cycle after it: s_ready=0, frame_valid=0, frame_data=0, fill_level=0.
  - s_ready follows its normal rule from the second cycle after reset.
  - Reset mid-frame discards all partial and complete frames; no frame_valid is produced for them.
- s_ready = !full[wr_bank] (registered-state function; no combinational path from s_valid or frame_ack).
- Write (s_valid && s_ready):
  - bank[wr_bank][idx] <= s_data, where idx = BITREV ? bitrev(wr_cnt) : wr_cnt.
  - wr_cnt increments.
- Frame close condition: the accepted sample has wr_cnt==N-1, or (USE_LAST && s_last). On close:
  - full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
- Length errors (USE_LAST=1):
  - Early s_last (wr_cnt<N-1): the frame closes; unwritten entries remain 0 (zero-padding); err_len <= 1.
  - Missing s_last at wr_cnt==N-1: the frame still closes; err_len <= 1.
  - err_len clears only on rst.
- s_valid without s_ready: sample not accepted; no state change; the source must hold the sample.
- Read side:
  - frame_valid = full[rd_bank].
  - frame_data = bank[rd_bank] when frame_valid, else 0. It is stable for as long as frame_valid=1.
- frame_ack && frame_valid:
  - full[rd_bank] <= 0; bank[rd_bank] zeroed; rd_bank toggles.
  - frame_ack while frame_valid=0 is ignored.
- Latency:
  - Closing sample accepted at edge t -> frame_valid=1 in the cycle after t (if that bank is rd_bank).
  - Ack at edge t -> the bank is free in the cycle after t; a stalled writer sees s_ready=1 in that cycle.
- Simultaneous events:
  - A close on one bank and an ack on the other in the same cycle both take effect.
  - A write can never target the bank being acked: it is full, so s_ready=0.
- Both banks full: s_ready=0 until an ack. The frame order is strictly preserved (alternating banks).
- fill_level = wr_cnt; it reads 0 while the write bank is full.
- No arithmetic on the data; samples are stored bit-exact.

Decomposition:
- Package fft_pkg holds:
  - ADDR_W = $clog2(N) and LVL_W = $clog2(N)+1 constants.
  - The function bitrev(value, width).
  - The bank-select typedef (1 bit).
- Sub-module fft_bitrev_idx: combinational wr_cnt -> idx mapper, with BITREV bypass. Instantiated once.
- Bank storage and FSM stay in fft_frame_buffer.

Test Plan:
- N=8, BITREV=1: stream samples 0x0000..0x0007 with s_last on the 8th.
  - frame_valid rises 1 cycle after the last sample.
  - Entries 0..7 read 0,4,2,6,1,5,3,7.
  - err_len=0.
- Ping-pong with BITREV=0, frame_ack held 0:
  - Stream 16 samples back-to-back; the second frame fills bank 1.
  - On the 17th sample s_ready=0 and fill_level=0.
  - Pulse ack: frame_data switches to samples 8..15, and s_ready=1 the next cycle.
- Early s_last on the 5th sample (N=8, BITREV=0), data 0x11..0x15:
  - Frame closes; entries 5..7 read 0; err_len=1 and stays 1 through later good frames.
- Missing s_last with USE_LAST=1:
  - 8 samples with no s_last -> the frame closes at 8 and err_len=1.
  - Same test with USE_LAST=0 -> err_len stays 0.
- Simultaneous events: close bank 1 in the same cycle frame_ack releases bank 0.
  - Next cycle: frame_valid=1 showing bank 1 and s_ready=1.
  - Spurious frame_ack with frame_valid=0 changes nothing.
- Reset mid-frame: assert rst after 3 samples, with one full bank pending.
  - Next cycle: frame_valid=0, frame_data=0, fill_level=0.
  - s_ready stays 0 for one cycle after rst, then reads 1.
  - A fresh 8-sample frame is then captured correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, bank-select type and bit-reversal helper for the FFT frame buffer.
package fft_pkg;

  // Widths for the default 16-point configuration; modules derive their own from N.
  localparam int unsigned DEF_N  = 16;
  localparam int unsigned ADDR_W = $clog2(DEF_N);
  localparam int unsigned LVL_W  = $clog2(DEF_N) + 1;

  typedef logic bank_sel_t;

  // Reverse the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
    logic [31:0] v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r = {r[30:0], v[0]};
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_idx.sv
// Maps the running write count to the storage slot: bit-reversed or natural order.
module fft_bitrev_idx
  import fft_pkg::*;
#(
  parameter int unsigned AddrW  = 4,
  parameter bit          BitRev = 1'b1
) (
  input  logic [AddrW-1:0] cnt_i,
  output logic [AddrW-1:0] idx_o
);

  // Pure combinational mapping; BitRev=0 is a straight bypass.
  always_comb begin
    idx_o = BitRev ? AddrW'(bitrev(32'(cnt_i), AddrW)) : cnt_i;
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame store: serial samples in, one full N-sample frame out as a flat bus.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned MSB      = 16,
  parameter bit          BITREV   = 1'b1,
  parameter bit          USE_LAST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [MSB-1:0]        s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  frame_valid,
  output logic [N*MSB-1:0]      frame_data,
  input  logic                  frame_ack,
  output logic [$clog2(N):0]    fill_level,
  output logic                  err_len
);

  localparam int unsigned AddrW = $clog2(N);

  logic [MSB-1:0]   bank_q [2][N];
  logic [MSB-1:0]   bank_d [2][N];
  logic [1:0]       full_q, full_d;
  bank_sel_t        wr_bank_q, wr_bank_d;
  bank_sel_t        rd_bank_q, rd_bank_d;
  logic [AddrW-1:0] wr_cnt_q, wr_cnt_d;
  logic             err_q, err_d;
  // Holds s_ready low for the first cycle after reset.
  logic             armed_q, armed_d;

  logic [AddrW-1:0] wr_idx;
  logic             accept, ack, last_slot, close;

  fft_bitrev_idx #(
    .AddrW  (AddrW),
    .BitRev (BITREV)
  ) u_idx (
    .cnt_i (wr_cnt_q),
    .idx_o (wr_idx)
  );

  // Handshake decode and next-state for banks, fill count and error flag.
  always_comb begin
    s_ready     = armed_q && !full_q[wr_bank_q];
    frame_valid = full_q[rd_bank_q];
    accept      = s_valid && s_ready;
    ack         = frame_ack && frame_valid;
    last_slot   = (wr_cnt_q == AddrW'(N - 1));
    close       = accept && (last_slot || (USE_LAST && s_last));

    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = err_q;
    armed_d   = 1'b1;

    if (accept) begin
      bank_d[wr_bank_q][wr_idx] = s_data;
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    if (close) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_cnt_d          = '0;
      // Early s_last or a missing s_last on the final slot both flag a length error.
      if (USE_LAST && (s_last != last_slot)) begin
        err_d = 1'b1;
      end
    end

    // Never collides with the write above: the acked bank is full, so it is not writable.
    if (ack) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      for (int i = 0; i < int'(N); i++) begin
        bank_d[rd_bank_q][i] = '0;
      end
    end
  end

  // Present the read bank only while it holds a complete frame.
  always_comb begin
    frame_data = '0;
    if (frame_valid) begin
      for (int i = 0; i < int'(N); i++) begin
        frame_data[i*MSB +: MSB] = bank_q[rd_bank_q][i];
      end
    end
    fill_level = {1'b0, wr_cnt_q};
    err_len    = err_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(N); i++) begin
          bank_q[b][i] <= '0;
        end
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

endmodule
